// File: rtl/keypad_fsm.sv
// Multi-tap keypad letter entry: decodes row/column key presses into ASCII letters and submits guesses.
// Latency: one clock from strobe to every output; no backpressure, every strobe is consumed in its own cycle.
module keypad_fsm #(
    parameter logic [31:0] TIMEOUT = 32'd10_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       strobe,
    input  logic [7:0] cur_key,
    output logic [7:0] letter,
    output logic       letter_valid,
    output logic [7:0] guess,
    output logic       guess_valid
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        TAPPING = 2'd1,
        LOCKED  = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        K_NONE   = 2'd0,
        K_LETTER = 2'd1,
        K_SUBMIT = 2'd2,
        K_CLEAR  = 2'd3
    } kind_t;

    localparam logic [31:0] TMO_LAST = TIMEOUT - 32'd1;

    state_t      state_q,      state_d;
    logic [3:0]  key_q,        key_d;
    logic [1:0]  idx_q,        idx_d;
    logic [31:0] timer_q,      timer_d;
    logic [7:0]  letter_q,     letter_d;
    logic        letter_vld_q, letter_vld_d;
    logic [7:0]  guess_q,      guess_d;
    logic        guess_vld_q,  guess_vld_d;

    logic [1:0]  row_idx;
    logic        row_ok;
    logic [1:0]  col_idx;
    logic        col_ok;
    kind_t       kind;
    logic [3:0]  digit;

    // First letter of each digit's group; the tap index is added on top.
    function automatic logic [7:0] letter_of(input logic [3:0] d, input logic [1:0] i);
        logic [7:0] base;
        case (d)
            4'd2:    base = 8'h41;
            4'd3:    base = 8'h44;
            4'd4:    base = 8'h47;
            4'd5:    base = 8'h4A;
            4'd6:    base = 8'h4D;
            4'd7:    base = 8'h50;
            4'd8:    base = 8'h54;
            4'd9:    base = 8'h57;
            default: base = 8'h00;
        endcase
        return base + {6'd0, i};
    endfunction

    function automatic logic [1:0] last_idx(input logic [3:0] d);
        return ((d == 4'd7) || (d == 4'd9)) ? 2'd3 : 2'd2;
    endfunction

    // Row is one-hot active-high, column one-hot active-low.
    always_comb begin
        row_idx = 2'd0;
        row_ok  = 1'b1;
        case (cur_key[7:4])
            4'b1000: row_idx = 2'd0;
            4'b0100: row_idx = 2'd1;
            4'b0010: row_idx = 2'd2;
            4'b0001: row_idx = 2'd3;
            default: row_ok  = 1'b0;
        endcase

        col_idx = 2'd0;
        col_ok  = 1'b1;
        case (cur_key[3:0])
            4'b0111: col_idx = 2'd0;
            4'b1011: col_idx = 2'd1;
            4'b1101: col_idx = 2'd2;
            4'b1110: col_idx = 2'd3;
            default: col_ok  = 1'b0;
        endcase
    end

    always_comb begin
        kind  = K_NONE;
        digit = 4'd0;
        if (strobe && row_ok && col_ok) begin
            case ({row_idx, col_idx})
                4'h1: begin kind = K_LETTER; digit = 4'd2; end
                4'h2: begin kind = K_LETTER; digit = 4'd3; end
                4'h3: kind = K_SUBMIT;
                4'h4: begin kind = K_LETTER; digit = 4'd4; end
                4'h5: begin kind = K_LETTER; digit = 4'd5; end
                4'h6: begin kind = K_LETTER; digit = 4'd6; end
                4'h7: kind = K_CLEAR;
                4'h8: begin kind = K_LETTER; digit = 4'd7; end
                4'h9: begin kind = K_LETTER; digit = 4'd8; end
                4'hA: begin kind = K_LETTER; digit = 4'd9; end
                default: kind = K_NONE;
            endcase
        end
    end

    // A decoded strobe always wins over the timeout landing in the same cycle.
    always_comb begin
        state_d      = state_q;
        key_d        = key_q;
        idx_d        = idx_q;
        timer_d      = timer_q;
        letter_d     = letter_q;
        letter_vld_d = letter_vld_q;
        guess_d      = guess_q;
        guess_vld_d  = 1'b0;

        case (kind)
            K_CLEAR: begin
                state_d      = IDLE;
                idx_d        = 2'd0;
                timer_d      = 32'd0;
                letter_d     = 8'h00;
                letter_vld_d = 1'b0;
            end
            K_SUBMIT: begin
                if (state_q != IDLE) begin
                    state_d      = IDLE;
                    idx_d        = 2'd0;
                    timer_d      = 32'd0;
                    guess_d      = letter_q;
                    guess_vld_d  = 1'b1;
                    letter_d     = 8'h00;
                    letter_vld_d = 1'b0;
                end
            end
            K_LETTER: begin
                state_d      = TAPPING;
                key_d        = digit;
                timer_d      = 32'd0;
                letter_vld_d = 1'b1;
                if ((state_q == TAPPING) && (digit == key_q)) begin
                    idx_d = (idx_q == last_idx(digit)) ? 2'd0 : idx_q + 2'd1;
                end else begin
                    idx_d = 2'd0;
                end
                letter_d = letter_of(digit, idx_d);
            end
            default: begin
                if (state_q == TAPPING) begin
                    if (timer_q >= TMO_LAST) begin
                        state_d = LOCKED;
                        timer_d = TIMEOUT;
                    end else begin
                        timer_d = timer_q + 32'd1;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            key_q        <= 4'd0;
            idx_q        <= 2'd0;
            timer_q      <= 32'd0;
            letter_q     <= 8'h00;
            letter_vld_q <= 1'b0;
            guess_q      <= 8'h00;
            guess_vld_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            key_q        <= key_d;
            idx_q        <= idx_d;
            timer_q      <= timer_d;
            letter_q     <= letter_d;
            letter_vld_q <= letter_vld_d;
            guess_q      <= guess_d;
            guess_vld_q  <= guess_vld_d;
        end
    end

    assign letter       = letter_q;
    assign letter_valid = letter_vld_q;
    assign guess        = guess_q;
    assign guess_valid  = guess_vld_q;

endmodule

// File: tb/tb_keypad_fsm.sv
// Directed bench for keypad_fsm: stimulus queues the expected post-edge outputs, a monitor compares them each cycle.
module tb_keypad_fsm;

    logic       clk;
    logic       rst;
    logic       strobe;
    logic [7:0] cur_key;
    logic [7:0] letter;
    logic       letter_valid;
    logic [7:0] guess;
    logic       guess_valid;

    typedef struct {
        logic [7:0] letter;
        logic       lv;
        logic [7:0] guess;
        logic       gv;
        string      tag;
    } exp_t;

    exp_t exp_q[$];

    logic [7:0] exp_letter;
    logic [7:0] exp_guess;
    logic       exp_gv;
    int         n_cmp;
    int         n_err;

    keypad_fsm #(.TIMEOUT(32'd16)) dut (
        .clk          (clk),
        .rst          (rst),
        .strobe       (strobe),
        .cur_key      (cur_key),
        .letter       (letter),
        .letter_valid (letter_valid),
        .guess        (guess),
        .guess_valid  (guess_valid)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // One clock of stimulus; the expectation describes the outputs after this edge.
    task automatic step(input logic s, input logic [7:0] k, input string tag);
        exp_t e;
        strobe  = s;
        cur_key = k;
        @(posedge clk);
        e.letter = exp_letter;
        e.lv     = (exp_letter != 8'h00);
        e.guess  = exp_guess;
        e.gv     = exp_gv;
        e.tag    = tag;
        exp_q.push_back(e);
        #1;
        strobe = 1'b0;
        exp_gv = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 8'h00, "idle");
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                exp_t e;
                e = exp_q.pop_front();
                n_cmp++;
                if (letter !== e.letter || letter_valid !== e.lv ||
                    guess !== e.guess || guess_valid !== e.gv) begin
                    n_err++;
                    $display("FAIL %s: got letter=%h lv=%b guess=%h gv=%b, want letter=%h lv=%b guess=%h gv=%b",
                             e.tag, letter, letter_valid, guess, guess_valid,
                             e.letter, e.lv, e.guess, e.gv);
                end
            end
        end
    end

    initial begin
        n_cmp      = 0;
        n_err      = 0;
        rst        = 1'b1;
        strobe     = 1'b1;
        cur_key    = 8'h8B;
        exp_letter = 8'h00;
        exp_guess  = 8'h00;
        exp_gv     = 1'b0;

        // Reset with a live strobe on key 2
        for (int i = 0; i < 3; i++) step(1'b1, 8'h8B, "rst_strobe");
        rst = 1'b0;
        step(1'b0, 8'h8B, "post_rst_nostrobe");

        // Key 2 multi-tap with wrap
        exp_letter = 8'h41; step(1'b1, 8'h8B, "k2_a"); idle(2);
        exp_letter = 8'h42; step(1'b1, 8'h8B, "k2_b"); idle(2);
        exp_letter = 8'h43; step(1'b1, 8'h8B, "k2_c"); idle(2);
        exp_letter = 8'h41; step(1'b1, 8'h8B, "k2_wrap");

        // Ignored and malformed keys leave everything untouched
        step(1'b1, 8'h87, "ign_key1");
        step(1'b1, 8'h00, "ign_zero");
        step(1'b1, 8'hCB, "ign_two_rows");
        step(1'b1, 8'h8F, "ign_no_col");
        step(1'b1, 8'h1B, "ign_key0");
        step(1'b1, 8'h17, "ign_star");
        step(1'b1, 8'h1D, "ign_hash");
        step(1'b1, 8'h2E, "ign_keyC");
        step(1'b1, 8'h1E, "ign_keyD");
        step(1'b0, 8'h8B, "ign_nostrobe");
        exp_letter = 8'h42; step(1'b1, 8'h8B, "k2_after_ign");

        // Switching keys mid-sequence restarts at the first letter
        exp_letter = 8'h44; step(1'b1, 8'h8D, "k3_d");
        exp_letter = 8'h45; step(1'b1, 8'h8D, "k3_e");
        exp_letter = 8'h4D; step(1'b1, 8'h4D, "k6_m");
        exp_letter = 8'h57; step(1'b1, 8'h2D, "k9_w");
        exp_letter = 8'h58; step(1'b1, 8'h2D, "k9_x");
        exp_letter = 8'h59; step(1'b1, 8'h2D, "k9_y");
        exp_letter = 8'h5A; step(1'b1, 8'h2D, "k9_z");
        exp_letter = 8'h57; step(1'b1, 8'h2D, "k9_wrap");
        exp_letter = 8'h54; step(1'b1, 8'h2B, "k8_t");
        exp_letter = 8'h55; step(1'b1, 8'h2B, "k8_u");
        exp_letter = 8'h56; step(1'b1, 8'h2B, "k8_v");
        exp_letter = 8'h54; step(1'b1, 8'h2B, "k8_wrap");
        exp_letter = 8'h00; step(1'b1, 8'h4E, "clear_k8"); idle(1);

        // Key 7 to S, then submit
        exp_letter = 8'h50; step(1'b1, 8'h27, "k7_p"); idle(1);
        exp_letter = 8'h51; step(1'b1, 8'h27, "k7_q"); idle(1);
        exp_letter = 8'h52; step(1'b1, 8'h27, "k7_r"); idle(1);
        exp_letter = 8'h53; step(1'b1, 8'h27, "k7_s"); idle(1);
        exp_letter = 8'h00; exp_guess = 8'h53; exp_gv = 1'b1;
        step(1'b1, 8'h8E, "submit_s");
        idle(2);
        step(1'b1, 8'h8E, "submit_idle");
        idle(1);

        // Timeout locks the sequence; the same key then restarts it
        exp_letter = 8'h4A; step(1'b1, 8'h4B, "k5_first"); idle(20);
        step(1'b1, 8'h4B, "k5_after_lock");
        exp_letter = 8'h00; step(1'b1, 8'h4E, "clear_k5");
        exp_letter = 8'h4A; step(1'b1, 8'h4B, "k5_first2"); idle(16);
        step(1'b1, 8'h4B, "k5_just_locked");
        exp_letter = 8'h00; step(1'b1, 8'h4E, "clear_k5b");
        exp_letter = 8'h4A; step(1'b1, 8'h4B, "k5_first3"); idle(15);
        exp_letter = 8'h4B; step(1'b1, 8'h4B, "k5_precedence");
        exp_letter = 8'h00; exp_guess = 8'h4B; exp_gv = 1'b1;
        step(1'b1, 8'h8E, "submit_k");
        idle(1);

        // Submit from the locked state
        exp_letter = 8'h4D; step(1'b1, 8'h4D, "k6_lockpath"); idle(17);
        exp_letter = 8'h00; exp_guess = 8'h4D; exp_gv = 1'b1;
        step(1'b1, 8'h8E, "submit_locked");
        idle(1);

        // Clear then submit yields no guess
        exp_letter = 8'h47; step(1'b1, 8'h47, "k4_g");
        exp_letter = 8'h00; step(1'b1, 8'h4E, "clear_g");
        step(1'b1, 8'h8E, "submit_after_clear");
        idle(1);

        // Reset mid-sequence with a submit strobe discards everything
        exp_letter = 8'h57; step(1'b1, 8'h2D, "k9_pre_rst");
        rst = 1'b1;
        exp_letter = 8'h00; exp_guess = 8'h00;
        step(1'b1, 8'h8E, "rst_mid");
        rst = 1'b0;
        step(1'b0, 8'h00, "post_rst_mid");
        exp_letter = 8'h41; step(1'b1, 8'h8B, "resume_k2");

        repeat (3) @(negedge clk);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
